// File: rtl/dmem_loader_pkg.sv
// dmem_loader_pkg: shared types and constants for the data-memory loader.
package dmem_loader_pkg;

    localparam int DATA_REGION_WORDS = 32;
    localparam int WORD_BYTES        = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COLLECT = 3'd1,
        ST_WRITE   = 3'd2,
        ST_VERIFY  = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

    // Byte address of a data-region word: the index wraps modulo 32 and
    // addr[7] stays 0, so the I/O region can never be reached.
    function automatic logic [31:0] word_addr(input int unsigned base,
                                              input logic [4:0] index);
        logic [4:0] wi;
        wi = 5'(base) + index;
        return {24'b0, 1'b0, wi, 2'b00};
    endfunction

endpackage

// File: rtl/dmem_loader_byte_packer.sv
// dmem_loader_byte_packer: little-endian assembly of four stream bytes into
// one word. word_o already contains the byte pushed this cycle, so the FSM
// can register the finished word on the same edge as the fourth transfer.
module dmem_loader_byte_packer
    import dmem_loader_pkg::*;
(
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        clear_i,
    input  logic        push_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_full_o
);

    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [31:0] word_q, word_d;

    // Next-state: clear on a new load, otherwise insert the byte at its lane.
    always_comb begin
        byte_cnt_d = byte_cnt_q;
        word_d     = word_q;
        if (clear_i) begin
            byte_cnt_d = 2'd0;
            word_d     = 32'd0;
        end else if (push_i) begin
            word_d[{byte_cnt_q, 3'b000} +: 8] = byte_i;
            byte_cnt_d = byte_cnt_q + 2'd1;
        end
    end

    // Lane counter and partial word registers.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            byte_cnt_q <= 2'd0;
            word_q     <= 32'd0;
        end else begin
            byte_cnt_q <= byte_cnt_d;
            word_q     <= word_d;
        end
    end

    assign word_o      = word_d;
    assign word_full_o = push_i && !clear_i && (byte_cnt_q == 2'(WORD_BYTES - 1));

endmodule

// File: rtl/dmem_loader.sv
// dmem_loader: accepts a byte stream, packs it into words and writes them to
// consecutive data-memory words through the CPU's store port.
// Optional feature macro: DMEM_LOADER_VERIFY_EN adds a one-cycle readback
// check after every write and a sticky error flag.
// Handshake: a byte transfers on a rising edge where byte_valid and
// byte_ready are both high; byte_ready is registered, high only in COLLECT,
// and the producer must hold byte_in stable while byte_valid waits.
module dmem_loader
    import dmem_loader_pkg::*;
#(
    parameter int BASE_WORD = 0,
    parameter int NUM_WORDS = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic [31:0] addr,
    output logic [31:0] datain,
    output logic        we,
    input  logic [31:0] dataout,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [5:0]  word_count,
    output state_e      dbg_state
);

    localparam logic [4:0] LAST_INDEX = 5'(NUM_WORDS - 1);

    state_e      state_q, state_d;
    logic [4:0]  index_q, index_d;
    logic [5:0]  word_count_q, word_count_d;
    logic        byte_ready_q, byte_ready_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] datain_q, datain_d;
    logic        advance;
    logic        pk_clear, pk_push, pk_full;
    logic [31:0] pk_word;

    assign pk_push = (state_q == ST_COLLECT) && byte_valid && byte_ready_q;

    dmem_loader_byte_packer u_packer (
        .clock_i     (clock),
        .reset_i     (reset),
        .clear_i     (pk_clear),
        .push_i      (pk_push),
        .byte_i      (byte_in),
        .word_o      (pk_word),
        .word_full_o (pk_full)
    );

`ifdef DMEM_LOADER_VERIFY_EN
    logic error_q, error_d;
`endif

    // Next-state and registered bus outputs; every target defaulted first.
    always_comb begin
        state_d      = state_q;
        index_d      = index_q;
        word_count_d = word_count_q;
        byte_ready_d = 1'b0;
        we_d         = 1'b0;
        addr_d       = addr_q;
        datain_d     = datain_q;
        pk_clear     = 1'b0;
        advance      = 1'b0;
`ifdef DMEM_LOADER_VERIFY_EN
        error_d      = error_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d      = ST_COLLECT;
                    index_d      = 5'd0;
                    word_count_d = 6'd0;
                    byte_ready_d = 1'b1;
                    pk_clear     = 1'b1;
`ifdef DMEM_LOADER_VERIFY_EN
                    error_d      = 1'b0;
`endif
                end
            end
            ST_COLLECT: begin
                byte_ready_d = 1'b1;
                if (pk_full) begin
                    state_d      = ST_WRITE;
                    byte_ready_d = 1'b0;
                    we_d         = 1'b1;
                    addr_d       = word_addr(BASE_WORD, index_q);
                    datain_d     = pk_word;
                end
            end
            ST_WRITE: begin
                word_count_d = word_count_q + 6'd1;
`ifdef DMEM_LOADER_VERIFY_EN
                state_d      = ST_VERIFY;
`else
                advance      = 1'b1;
`endif
            end
`ifdef DMEM_LOADER_VERIFY_EN
            ST_VERIFY: begin
                // addr is still held, so dataout is the word just written.
                if (dataout != datain_q) begin
                    error_d = 1'b1;
                end
                advance = 1'b1;
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        if (advance) begin
            if (index_q == LAST_INDEX) begin
                state_d = ST_DONE;
            end else begin
                index_d      = index_q + 5'd1;
                state_d      = ST_COLLECT;
                byte_ready_d = 1'b1;
            end
        end
    end

    // State and output registers; reset abandons any partial word.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            index_q      <= 5'd0;
            word_count_q <= 6'd0;
            byte_ready_q <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= 32'd0;
            datain_q     <= 32'd0;
        end else begin
            state_q      <= state_d;
            index_q      <= index_d;
            word_count_q <= word_count_d;
            byte_ready_q <= byte_ready_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            datain_q     <= datain_d;
        end
    end

`ifdef DMEM_LOADER_VERIFY_EN
    // Sticky readback-mismatch flag, cleared only by start or reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            error_q <= 1'b0;
        end else begin
            error_q <= error_d;
        end
    end

    assign error = error_q;
`else
    logic unused_dataout;
    assign unused_dataout = ^dataout;
    assign error = 1'b0;
`endif

    assign byte_ready = byte_ready_q;
    assign addr       = addr_q;
    assign datain     = datain_q;
    assign we         = we_q;
    assign word_count = word_count_q;
    assign busy       = (state_q == ST_COLLECT) || (state_q == ST_WRITE) ||
                        (state_q == ST_VERIFY);
    assign done       = (state_q == ST_DONE);
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_dmem_loader.sv
// tb_dmem_loader: three loader instances (base 0 / 31 / 29) sharing one byte
// stream, each with its own start and its own little memory model.
`timescale 1ns/1ps
module tb_dmem_loader;
    import dmem_loader_pkg::*;

    localparam int NI    = 3;
    localparam int BASE2 = 29;
    localparam int NUM2  = 5;

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        start_v      [NI];
    logic        byte_ready_v [NI];
    logic [31:0] addr_v       [NI];
    logic [31:0] datain_v     [NI];
    logic [31:0] dataout_v    [NI];
    logic        we_v         [NI];
    logic        busy_v       [NI];
    logic        done_v       [NI];
    logic        error_v      [NI];
    logic [5:0]  wc_v         [NI];
    state_e      st_v         [NI];

    logic [31:0] mem          [NI][32];
    logic        corrupt_en   [NI];
    logic [4:0]  corrupt_word [NI];
    logic [65:0] wlog[$];
    logic [63:0] exp_q[$];

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          inst;
        logic [31:0] w0;
        logic [31:0] w1;
        int          gap;
        logic [31:0] exp_addr0;
        logic [31:0] exp_addr1;
        logic [5:0]  exp_wc;
    } vec_t;

    // ---------------- clock ----------------
    always #5 clock = ~clock;

    // ---------------- DUTs ----------------
    dmem_loader #(.BASE_WORD(0), .NUM_WORDS(2)) u_dut0 (
        .clock(clock), .reset(reset), .start(start_v[0]), .byte_in(byte_in),
        .byte_valid(byte_valid), .byte_ready(byte_ready_v[0]), .addr(addr_v[0]),
        .datain(datain_v[0]), .we(we_v[0]), .dataout(dataout_v[0]), .busy(busy_v[0]),
        .done(done_v[0]), .error(error_v[0]), .word_count(wc_v[0]), .dbg_state(st_v[0]));

    dmem_loader #(.BASE_WORD(31), .NUM_WORDS(2)) u_dut1 (
        .clock(clock), .reset(reset), .start(start_v[1]), .byte_in(byte_in),
        .byte_valid(byte_valid), .byte_ready(byte_ready_v[1]), .addr(addr_v[1]),
        .datain(datain_v[1]), .we(we_v[1]), .dataout(dataout_v[1]), .busy(busy_v[1]),
        .done(done_v[1]), .error(error_v[1]), .word_count(wc_v[1]), .dbg_state(st_v[1]));

    dmem_loader #(.BASE_WORD(BASE2), .NUM_WORDS(NUM2)) u_dut2 (
        .clock(clock), .reset(reset), .start(start_v[2]), .byte_in(byte_in),
        .byte_valid(byte_valid), .byte_ready(byte_ready_v[2]), .addr(addr_v[2]),
        .datain(datain_v[2]), .we(we_v[2]), .dataout(dataout_v[2]), .busy(busy_v[2]),
        .done(done_v[2]), .error(error_v[2]), .word_count(wc_v[2]), .dbg_state(st_v[2]));

    // ---------------- memory model: commit in low phase, async read ----------------
    always @(negedge clock) begin
        for (int k = 0; k < NI; k++) begin
            if (we_v[k] === 1'b1) mem[k][addr_v[k][6:2]] <= datain_v[k];
        end
    end

    assign dataout_v[0] = mem[0][addr_v[0][6:2]] ^
        ((corrupt_en[0] && addr_v[0][6:2] == corrupt_word[0]) ? 32'h1 : 32'h0);
    assign dataout_v[1] = mem[1][addr_v[1][6:2]] ^
        ((corrupt_en[1] && addr_v[1][6:2] == corrupt_word[1]) ? 32'h1 : 32'h0);
    assign dataout_v[2] = mem[2][addr_v[2][6:2]] ^
        ((corrupt_en[2] && addr_v[2][6:2] == corrupt_word[2]) ? 32'h1 : 32'h0);

    // Write monitor: one entry per cycle with we high.
    always @(posedge clock) begin
        for (int k = 0; k < NI; k++) begin
            if (we_v[k] === 1'b1) wlog.push_back({2'(k), addr_v[k], datain_v[k]});
        end
    end

    // ---------------- driver tasks ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_start(input int k);
        start_v[k] = 1'b1;
        byte_valid = 1'b0;
        tick();
        start_v[k] = 1'b0;
    endtask

    // Returns #1 after the edge that transferred the byte.
    task automatic send_byte(input int k, input logic [7:0] b);
        int n;
        n = 0;
        byte_in    = b;
        byte_valid = 1'b1;
        @(negedge clock);
        while (byte_ready_v[k] !== 1'b1 && n < 40) begin
            n++;
            @(negedge clock);
        end
        if (byte_ready_v[k] !== 1'b1) check("byte_accept_timeout", 64'd0, 64'd1);
        @(posedge clock);
        #1;
        byte_valid = 1'b0;
    endtask

    // Four bytes, optional stall of gap cycles between bytes 2 and 3.
    task automatic send_word(input int k, input logic [31:0] w, input int gap);
        int bad;
        int logsz;
        send_byte(k, w[7:0]);
        send_byte(k, w[15:8]);
        if (gap > 0) begin
            bad   = 0;
            logsz = wlog.size();
            for (int i = 0; i < gap; i++) begin
                @(negedge clock);
                if (byte_ready_v[k] !== 1'b1 || we_v[k] !== 1'b0) bad++;
                tick();
            end
            check("stall_ready_held", 64'(bad), 64'd0);
            check("stall_no_write", 64'(wlog.size()), 64'(logsz));
        end
        send_byte(k, w[23:16]);
        send_byte(k, w[31:24]);
    endtask

    task automatic wait_done(input int k, input string name);
        int n;
        n = 0;
        while (done_v[k] !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        check(name, 64'(done_v[k]), 64'd1);
    endtask

    // ---------------- global time bound ----------------
    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        vec_t        vecs[4];
        logic [7:0]  rbytes[NUM2*4];
        logic [31:0] w;
        int          k;

        vecs[0] = '{inst: 0, w0: 32'h44332211, w1: 32'h88776655, gap: 0,
                    exp_addr0: 32'h00, exp_addr1: 32'h04, exp_wc: 6'd2};
        vecs[1] = '{inst: 0, w0: 32'h44332211, w1: 32'h88776655, gap: 3,
                    exp_addr0: 32'h00, exp_addr1: 32'h04, exp_wc: 6'd2};
        vecs[2] = '{inst: 1, w0: 32'hA5A55A5A, w1: 32'hFFFFFFFF, gap: 0,
                    exp_addr0: 32'h7C, exp_addr1: 32'h00, exp_wc: 6'd2};
        vecs[3] = '{inst: 1, w0: 32'h00000000, w1: 32'h80000001, gap: 1,
                    exp_addr0: 32'h7C, exp_addr1: 32'h00, exp_wc: 6'd2};

        reset      = 1'b1;
        byte_in    = 8'h00;
        byte_valid = 1'b0;
        for (int i = 0; i < NI; i++) begin
            start_v[i]      = 1'b0;
            corrupt_en[i]   = 1'b0;
            corrupt_word[i] = 5'd0;
        end
        tick(); tick(); tick();
        reset = 1'b0;

        // Reset values.
        @(negedge clock);
        for (int i = 0; i < NI; i++) begin
            check("reset_addr_data", {addr_v[i], datain_v[i]}, 64'd0);
            check("reset_flags", 64'({byte_ready_v[i], we_v[i], busy_v[i], done_v[i],
                                      error_v[i], wc_v[i]}), 64'd0);
            check("reset_state", 64'(st_v[i]), 64'(ST_IDLE));
        end
        tick();

        // Table-driven two-word loads.
        for (int v = 0; v < 4; v++) begin
            k = vecs[v].inst;
            wlog.delete();
            // Bytes offered while idle/done must be ignored.
            byte_in    = 8'hEE;
            byte_valid = 1'b1;
            tick();
            @(negedge clock);
            check("idle_ready_low", 64'(byte_ready_v[k]), 64'd0);
            tick();
            pulse_start(k);
            send_word(k, vecs[v].w0, vecs[v].gap);
            send_word(k, vecs[v].w1, vecs[v].gap);
            @(negedge clock);
            check("last_write_bus", {addr_v[k], datain_v[k]},
                  {vecs[v].exp_addr1, vecs[v].w1});
            check("last_write_flags", 64'({we_v[k], done_v[k], byte_ready_v[k]}), 64'b100);
            tick();
`ifdef DMEM_LOADER_VERIFY_EN
            @(negedge clock);
            check("verify_cycle", 64'({we_v[k], done_v[k], busy_v[k]}), 64'b001);
            tick();
`endif
            @(negedge clock);
            check("done_after_write", 64'({done_v[k], busy_v[k], byte_ready_v[k]}), 64'b100);
            check("word_count", 64'(wc_v[k]), 64'(vecs[v].exp_wc));
            check("we_cycles", 64'(wlog.size()), 64'd2);
            if (wlog.size() == 2) begin
                check("write0", 64'(wlog[0]), {vecs[v].exp_addr0, vecs[v].w0});
                check("write1", 64'(wlog[1]), {vecs[v].exp_addr1, vecs[v].w1});
                check("write_inst", 64'(wlog[1][65:64]), 64'(k));
            end
            tick();
        end

        // Reset in the middle of word 1 of a load.
        wlog.delete();
        pulse_start(0);
        send_byte(0, 8'hAB);
        send_byte(0, 8'hCD);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clock);
        check("midreset_state", 64'(st_v[0]), 64'(ST_IDLE));
        check("midreset_flags", 64'({we_v[0], busy_v[0], byte_ready_v[0], wc_v[0]}), 64'd0);
        check("midreset_no_write", 64'(wlog.size()), 64'd0);
        tick();
        pulse_start(0);
        send_word(0, 32'hCAFEF00D, 0);
        @(negedge clock);
        check("after_reset_write", {addr_v[0], datain_v[0]}, {32'h0, 32'hCAFEF00D});
        check("after_reset_we", 64'(we_v[0]), 64'd1);
        tick();
        send_word(0, 32'h12345678, 0);
        wait_done(0, "after_reset_done");
        check("after_reset_writes", 64'(wlog.size()), 64'd2);

        // start pulses while busy (COLLECT, then WRITE) are ignored.
        wlog.delete();
        pulse_start(0);
        send_byte(0, 8'h01);
        send_byte(0, 8'h02);
        pulse_start(0);
        send_byte(0, 8'h03);
        send_byte(0, 8'h04);
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        @(negedge clock);
        check("busy_start_wc", 64'(wc_v[0]), 64'd1);
        check("busy_start_busy", 64'(busy_v[0]), 64'd1);
        tick();
        send_word(0, 32'h08070605, 0);
        wait_done(0, "busy_start_done");
        check("busy_start_count", 64'(wlog.size()), 64'd2);
        if (wlog.size() == 2) begin
            check("busy_start_w0", 64'(wlog[0]), {32'h00, 32'h04030201});
            check("busy_start_w1", 64'(wlog[1]), {32'h04, 32'h08070605});
        end
        check("busy_start_wc_end", 64'(wc_v[0]), 64'd2);

        // Readback corruption of word 1.
        wlog.delete();
        corrupt_en[0]   = 1'b1;
        corrupt_word[0] = 5'd1;
        pulse_start(0);
        send_word(0, 32'h0BADF00D, 0);
        send_word(0, 32'h600DCAFE, 0);
        wait_done(0, "corrupt_done");
        check("corrupt_wc", 64'(wc_v[0]), 64'd2);
        check("corrupt_writes", 64'(wlog.size()), 64'd2);
`ifdef DMEM_LOADER_VERIFY_EN
        check("corrupt_error_set", 64'(error_v[0]), 64'd1);
        corrupt_en[0] = 1'b0;
        pulse_start(0);
        @(negedge clock);
        check("start_clears_error", 64'(error_v[0]), 64'd0);
        tick();
        send_word(0, 32'h11112222, 0);
        send_word(0, 32'h33334444, 0);
        wait_done(0, "clean_done");
        check("clean_error", 64'(error_v[0]), 64'd0);
`else
        check("error_tied_low", 64'(error_v[0]), 64'd0);
        corrupt_en[0] = 1'b0;
`endif

        // Randomized loads on the wrapping instance vs. reference model.
        for (int r = 0; r < 3; r++) begin
            wlog.delete();
            exp_q.delete();
            for (int i = 0; i < NUM2 * 4; i++) rbytes[i] = 8'($urandom_range(0, 255));
            for (int j = 0; j < NUM2; j++) begin
                w = 32'd0;
                for (int b = 0; b < 4; b++) w = w | (32'(rbytes[4*j+b]) << (8*b));
                exp_q.push_back({32'(((BASE2 + j) % 32) * 4), w});
            end
            pulse_start(2);
            for (int i = 0; i < NUM2 * 4; i++) begin
                int gap;
                gap = $urandom_range(0, 2);
                for (int g = 0; g < gap; g++) begin
                    byte_in = 8'($urandom_range(0, 255));
                    tick();
                end
                send_byte(2, rbytes[i]);
            end
            wait_done(2, "rand_done");
            check("rand_wc", 64'(wc_v[2]), 64'(NUM2));
            check("rand_count", 64'(wlog.size()), 64'(exp_q.size()));
            for (int i = 0; i < wlog.size() && i < exp_q.size(); i++) begin
                check("rand_write", 64'(wlog[i]), exp_q[i]);
                check("rand_addr7", 64'(wlog[i][39]), 64'd0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
